// File: rtl/button_capture.sv
// button_capture: debounced push-button word capture with a valid/ready handshake.
//
// A bouncing push-button and four quasi-static switches are synchronized and the
// button is debounced. Each debounced press latches the synchronized switch word
// and holds it on data_o until the consumer takes it with ready_i. A press that
// arrives while a word is still pending is discarded and flagged on drop_o.
//
// Optional feature: define BUTTON_CAPTURE_HAMMING_EN to present the latched word
// as a Hamming(7,4) codeword; otherwise data_o is {3'b000, word}.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   button       raw bouncing push-button, active-high
//   sw[3:0]      raw data switches
//   data_o[6:0]  captured (optionally encoded) word
//   valid_o      data_o is valid and pending
//   ready_i      consumer accepts data_o
//   drop_o       one-cycle pulse when a press is discarded
//   press_cnt_o  completed handshakes, modulo 256
module button_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic [3:0] sw,
  output logic [6:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       drop_o,
  output logic [7:0] press_cnt_o
);

  localparam logic [15:0] DebLimit = 16'(DEBOUNCE_CYCLES);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  logic       btn_meta_q, btn_sync_q;
  logic [3:0] sw_meta_q, sw_sync_q;
  logic       deb_q, deb_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic       rise_q, rise_d;
  state_e     state_q, state_d;
  logic [3:0] word_q, word_d;
  logic       drop_q, drop_d;
  logic [7:0] press_cnt_q, press_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      sw_meta_q   <= 4'h0;
      sw_sync_q   <= 4'h0;
      deb_q       <= 1'b0;
      cnt_q       <= 16'h0;
      rise_q      <= 1'b0;
      state_q     <= StIdle;
      word_q      <= 4'h0;
      drop_q      <= 1'b0;
      press_cnt_q <= 8'h0;
    end else begin
      btn_meta_q  <= button;
      btn_sync_q  <= btn_meta_q;
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      state_q     <= state_d;
      word_q      <= word_d;
      drop_q      <= drop_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  // Debouncer: count disagreeing cycles; flip once the run reaches the limit.
  // rise_q marks the cycle after a 0->1 flip and acts as the capture event.
  always_comb begin
    cnt_inc = cnt_q + 16'd1;
    deb_d   = deb_q;
    cnt_d   = 16'h0;
    rise_d  = 1'b0;
    if (btn_sync_q != deb_q) begin
      if (cnt_inc == DebLimit) begin
        deb_d  = ~deb_q;
        rise_d = ~deb_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Handshake FSM. A capture while pending is dropped even if the pending word
  // is accepted in that same cycle.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    drop_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise_q) begin
          state_d = StPend;
          word_d  = sw_sync_q;
        end
      end
      StPend: begin
        if (ready_i) begin
          state_d     = StIdle;
          press_cnt_d = press_cnt_q + 8'd1;
        end
        if (rise_q) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign valid_o     = (state_q == StPend);
  assign drop_o      = drop_q;
  assign press_cnt_o = press_cnt_q;

`ifdef BUTTON_CAPTURE_HAMMING_EN
  // d1..d4 = word[0..3]; layout {d4,d3,d2,p4,d1,p2,p1}.
  assign data_o = {word_q[3], word_q[2], word_q[1],
                   word_q[1] ^ word_q[2] ^ word_q[3],
                   word_q[0],
                   word_q[0] ^ word_q[2] ^ word_q[3],
                   word_q[0] ^ word_q[1] ^ word_q[3]};
`else
  assign data_o = {3'b000, word_q};
`endif

endmodule

// File: tb/tb_button_capture.sv
module tb_button_capture;

  localparam int unsigned D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       ready_i = 1'b0;
  logic [6:0] data_o;
  logic       valid_o;
  logic       drop_o;
  logic [7:0] press_cnt_o;

  int n_checks = 0;
  int n_fail = 0;

  button_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .button      (button),
    .sw          (sw),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .drop_o      (drop_o),
    .press_cnt_o (press_cnt_o)
  );

  always #5 clk = ~clk;

  // Expected output word for a 4-bit switch value.
  function automatic logic [6:0] enc(input logic [3:0] w);
`ifdef BUTTON_CAPTURE_HAMMING_EN
    logic d1, d2, d3, d4;
    d1 = w[0]; d2 = w[1]; d3 = w[2]; d4 = w[3];
    return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
`else
    return {3'b000, w};
`endif
  endfunction

  // Reference model: the button is seen two edges late; the debounced level
  // follows it once it has disagreed for D consecutive edges; a rising level
  // offers the switch word one edge later.
  typedef struct {
    logic       b1, b2;
    logic [3:0] w1, w2;
    logic       deb;
    int         run;
    logic       cap;
    logic       valid;
    logic [6:0] data;
    logic       drop;
    logic [7:0] cnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.b1 = 0; r.b2 = 0; r.w1 = 0; r.w2 = 0; r.deb = 0; r.run = 0; r.cap = 0;
    r.valid = 0; r.data = 0; r.drop = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input logic b, input logic [3:0] w,
                                        input logic rdy);
    model_t n;
    logic seen;
    n = c;
    seen = c.b2;
    n.b2 = c.b1; n.b1 = b; n.w2 = c.w1; n.w1 = w;
    n.drop = 0;
    if (c.valid && rdy) begin
      n.valid = 0;
      n.cnt = c.cnt + 8'd1;
    end
    if (c.cap) begin
      if (c.valid) n.drop = 1;
      else begin
        n.valid = 1;
        n.data = enc(c.w2);
      end
    end
    n.cap = 0;
    if (seen != c.deb) begin
      n.run = c.run + 1;
      if (n.run == int'(D)) begin
        n.deb = seen;
        n.run = 0;
        n.cap = seen;
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, button, sw, ready_i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; button = 1'b0; ready_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({data_o, valid_o, drop_o, press_cnt_o} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b drop=%b cnt=%0d, want all zero",
               data_o, valid_o, drop_o, press_cnt_o);
    end
  endtask

  task automatic test_clean_press();
    logic [6:0] want;
`ifdef BUTTON_CAPTURE_HAMMING_EN
    want = 7'h55;
`else
    want = 7'h0B;
`endif
    do_reset();
    sw = 4'b1011;
    repeat (4) tick();
    button = 1'b1;  // edge 0
    for (int k = 1; k <= int'(D) + 3; k++) begin
      tick();
      if (k == int'(D) + 2) begin
        n_checks++;
        if (valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_press_early: valid=%b at edge %0d, want 0", valid_o, k);
        end
      end
    end
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== want) begin
      n_fail++;
      $display("FAIL clean_press_edge19: valid=%b data=%h, want 1 and %h", valid_o, data_o, want);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || press_cnt_o !== 8'd1) begin
      n_fail++;
      $display("FAIL clean_press_handshake: valid=%b cnt=%0d, want 0 and 1", valid_o, press_cnt_o);
    end
    button = 1'b0;
    repeat (D + 6) tick();
  endtask

  task automatic test_bounce();
    int highs;
    do_reset();
    highs = 0;
    for (int k = 0; k < 140; k++) begin
      if (k < 100 && k % 5 == 0) button = ~button;
      if (k == 100) button = 1'b0;
      tick();
      if (valid_o !== 1'b0 || drop_o !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL bounce_ignored: %0d cycles with valid/drop high, want 0", highs);
    end
  endtask

  task automatic test_drop();
    int drops, moved;
    do_reset();
    sw = 4'b1011;
    repeat (3) tick();
    button = 1'b1;
    repeat (D + 3) tick();
    n_checks++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_first_press: valid=%b, want 1", valid_o);
    end
    button = 1'b0;
    repeat (D + 6) tick();
    sw = 4'b0110;
    button = 1'b1;
    drops = 0; moved = 0;
    repeat (D + 10) begin
      tick();
      if (drop_o === 1'b1) drops++;
      if (data_o !== enc(4'b1011) || valid_o !== 1'b1) moved++;
    end
    n_checks++;
    if (drops != 1) begin
      n_fail++;
      $display("FAIL drop_pulse_count: got %0d pulses, want 1", drops);
    end
    n_checks++;
    if (moved != 0) begin
      n_fail++;
      $display("FAIL drop_data_held: %0d cycles data/valid disturbed, want 0", moved);
    end
    button = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || press_cnt_o !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_handshake: valid=%b cnt=%0d, want 0 and 1", valid_o, press_cnt_o);
    end
    repeat (D + 6) tick();
  endtask

  task automatic test_wrap();
    int accepted;
    do_reset();
    ready_i = 1'b1;
    accepted = 0;
    for (int i = 0; i < 256; i++) begin
      sw = 4'($urandom);
      button = 1'b1;
      repeat (D + 6) begin
        tick();
        if (valid_o === 1'b1) accepted++;
      end
      button = 1'b0;
      repeat (D + 6) tick();
      if (i == 127) begin
        n_checks++;
        if (press_cnt_o !== 8'd128) begin
          n_fail++;
          $display("FAIL wrap_midway: cnt=%0d, want 128", press_cnt_o);
        end
      end
    end
    ready_i = 1'b0;
    n_checks++;
    if (accepted != 256) begin
      n_fail++;
      $display("FAIL wrap_accept_count: got %0d valid cycles, want 256", accepted);
    end
    n_checks++;
    if (press_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_to_zero: cnt=%0d, want 0", press_cnt_o);
    end
  endtask

  task automatic test_random();
    int bad, hold, drops;
    do_reset();
    bad = 0; hold = 0; drops = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        button = 1'($urandom);
        hold = (($urandom & 3) == 0) ? $urandom_range(1, 15) : $urandom_range(D, 45);
      end
      hold--;
      if ($urandom_range(0, 30) == 0) sw = 4'($urandom);
      ready_i = ($urandom_range(0, 9) == 0);
      tick();
      if (drop_o === 1'b1) drops++;
      if (valid_o !== m.valid || data_o !== m.data || drop_o !== m.drop ||
          press_cnt_o !== m.cnt) begin
        bad++;
        if (bad < 5)
          $display("FAIL random_vs_model cycle %0d: got v=%b d=%h dr=%b c=%0d, want v=%b d=%h dr=%b c=%0d",
                   k, valid_o, data_o, drop_o, press_cnt_o, m.valid, m.data, m.drop, m.cnt);
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_total: %0d mismatching cycles, want 0", bad);
    end
    $display("random: %0d drop pulses seen, press count %0d", drops, press_cnt_o);
    ready_i = 1'b0;
    button = 1'b0;
  endtask

  task automatic test_reset_mid();
    int spurious;
    do_reset();
    sw = 4'b0101;
    repeat (2) tick();
    button = 1'b1;
    repeat (D + 3) tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    button = 1'b0;
    repeat (D + 6) tick();
    button = 1'b1;
    repeat (D + 3) tick();
    n_checks++;
    if (valid_o !== 1'b1 || press_cnt_o !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_mid_setup: valid=%b cnt=%0d, want 1 and 1", valid_o, press_cnt_o);
    end
    button = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || press_cnt_o !== 8'd0 || data_o !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: valid=%b cnt=%0d data=%h, want 0 0 0",
               valid_o, press_cnt_o, data_o);
    end
    tick();
    rst_n = 1'b1;
    spurious = 0;
    repeat (D + 10) begin
      tick();
      if (valid_o !== 1'b0 || drop_o !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_capture: %0d spurious cycles, want 0", spurious);
    end
    // Button held across reset release: one capture at D+3 edges after release.
    rst_n = 1'b0;
    button = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= int'(D) + 3; k++) begin
      tick();
      if (k == int'(D) + 2) begin
        n_checks++;
        if (valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL held_reset_early: valid=%b at edge %0d, want 0", valid_o, k);
        end
      end
    end
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== enc(4'b0101)) begin
      n_fail++;
      $display("FAIL held_reset_capture: valid=%b data=%h, want 1 and %h",
               valid_o, data_o, enc(4'b0101));
    end
    ready_i = 1'b1;
    repeat (D + 10) begin
      tick();
      if (valid_o !== 1'b0 || drop_o !== 1'b0) spurious++;
    end
    ready_i = 1'b0;
    n_checks++;
    if (spurious != 0 || press_cnt_o !== 8'd1) begin
      n_fail++;
      $display("FAIL held_reset_single: %0d extra cycles cnt=%0d, want 0 and 1",
               spurious, press_cnt_o);
    end
    button = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_drop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_capture.md
BUTTON_CAPTURE -- requirements
Module: button_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive agreeing synchronized samples needed to change debounced button state (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port button  input  1  raw, asynchronous, bouncing push-button, active-high.
REQ-005 SHALL have port sw  input  4  raw data switches, quasi-static.
REQ-006 SHALL have port data_o  output  7  captured word.
REQ-007 SHALL have port valid_o  output  1  data_o is valid and pending.
REQ-008 SHALL have port ready_i  input  1  the consumer accepts data_o.
REQ-009 SHALL have port drop_o  output  1  one-cycle pulse when a press is discarded.
REQ-010 SHALL have port press_cnt_o  output  8  count of accepted captures, wraps.

Function
REQ-011 SHALL pass button and sw through a two-flop synchronizer each before any use.
REQ-012 SHALL hold a debounced state plus a 16-bit counter; the counter increments while the synchronized button differs from the debounced state and clears to 0 on any agreeing cycle.
REQ-013 SHALL toggle the debounced state and clear the counter on the cycle the counter would reach DEBOUNCE_CYCLES.
REQ-014 SHALL generate a capture event only on a debounced 0->1 transition; 1->0 transitions produce no event.
REQ-015 SHALL latch the synchronized sw into data_o on the edge after the capture event. With button held clean from edge 0, valid_o rises at edge DEBOUNCE_CYCLES+3.
REQ-016 SHALL implement FSM IDLE (valid_o=0) and PEND (valid_o=1): IDLE->PEND on capture; PEND->IDLE on a cycle with ready_i=1.
REQ-017 SHALL keep data_o and valid_o stable in PEND until the handshake completes; ready_i in IDLE is ignored.
REQ-018 SHALL increment press_cnt_o by 1 modulo 256 on each completed handshake (valid_o&ready_i); 255 wraps to 0.
REQ-019 SHALL, on a capture event while in PEND, discard the new sw value, keep the old data_o, and pulse drop_o high for exactly one cycle. This applies even when ready_i=1 in that same cycle.
REQ-020 SHALL ignore bounces shorter than DEBOUNCE_CYCLES cycles: no capture and no drop.

Reset
REQ-021 SHALL, on rst_n low, immediately clear synchronizers, debounced state, counter, FSM (IDLE), data_o=0, valid_o=0, drop_o=0, press_cnt_o=0.
REQ-022 SHALL discard a pending word or an in-progress debounce when reset asserts mid-operation. A button held through reset release SHALL produce exactly one capture, DEBOUNCE_CYCLES+3 edges after release.

Configuration
REQ-023 SHALL honour macro BUTTON_CAPTURE_HAMMING_EN. When defined, data_o is the Hamming(7,4) codeword with d1..d4=sw[0..3], p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4, and data_o[6:0]={d4,d3,d2,p4,d1,p2,p1}.
REQ-024 SHALL, without BUTTON_CAPTURE_HAMMING_EN, set data_o={3'b000,sw}. Encoding SHALL be combinational on the latched value, with no added latency.

Verification
REQ-025 SHALL cover: DEBOUNCE_CYCLES=16, sw=4'b1011, clean press -> valid_o at edge 19, data_o=7'h55 (macro) or 7'h0B (no macro).
REQ-026 SHALL cover: button toggles every 5 cycles for 100 cycles then stays low -> no valid_o, no drop_o.
REQ-027 SHALL cover: press with ready_i=0, second clean press while PEND -> one drop_o pulse, data_o unchanged; ready_i=1 -> valid_o falls, press_cnt_o=1.
REQ-028 SHALL cover: 256 press/handshake cycles with ready_i=1 -> press_cnt_o returns to 0.
REQ-029 SHALL cover: rst_n pulsed low while PEND -> valid_o=0 and press_cnt_o=0 within the same cycle, with no spurious capture after release when button is low.
